// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: opcode encoding
// and the per-bit operation evaluator used by the compute stage.
package logic_unit_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_NOT  = 3'd0;
  localparam logic [OPW-1:0] OP_AND  = 3'd1;
  localparam logic [OPW-1:0] OP_OR   = 3'd2;
  localparam logic [OPW-1:0] OP_XOR  = 3'd3;
  localparam logic [OPW-1:0] OP_NAND = 3'd4;
  localparam logic [OPW-1:0] OP_NOR  = 3'd5;
  localparam logic [OPW-1:0] OP_XNOR = 3'd6;
  localparam logic [OPW-1:0] OP_PASS = 3'd7;

  // Bit-sliced so the evaluator stays independent of the operand width.
  function automatic logic lu_eval_bit(input logic [OPW-1:0] op,
                                       input logic a,
                                       input logic b);
    logic r;
    r = 1'b0;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_vr.sv
// One valid/ready register slice. The payload is loaded only when a beat
// actually transfers in, so held data stays stable under backpressure.
module pipe_reg_vr #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;
  logic          w_adv;

  assign w_adv     = ~r_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  // Slice state: refill or drain whenever the slot is free to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {PW{1'b0}};
    end else begin
      if (w_adv) begin
        r_valid <= in_valid;
      end
      if (w_adv && in_valid) begin
        r_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined W-bit logic unit with valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to add the registered out_zero/out_par flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int W = 8,
  parameter int OPW = logic_unit_pkg::OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  input  logic           out_ready,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic           out_zero,
  output logic           out_par,
`endif
  output logic [W-1:0]   y
);

  localparam int S1W = 2 * W + OPW;
`ifdef LOGIC_UNIT_FLAGS_EN
  localparam int S2W = W + 2;
`else
  localparam int S2W = W;
`endif

  logic [S1W-1:0] w_s1_in;
  logic [S1W-1:0] w_s1_data;
  logic           w_s1_valid;
  logic           w_s2_in_ready;
  logic [W-1:0]   w_s1_a;
  logic [W-1:0]   w_s1_b;
  logic [OPW-1:0] w_s1_op;
  logic [W-1:0]   w_f;
  logic [S2W-1:0] w_s2_in;
  logic [S2W-1:0] w_s2_data;

  assign w_s1_in = {op, b, a};
  assign w_s1_a  = w_s1_data[W-1:0];
  assign w_s1_b  = w_s1_data[2*W-1:W];
  assign w_s1_op = w_s1_data[S1W-1:2*W];

  pipe_reg_vr #(.PW(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_s1_in),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_in_ready),
    .out_data  (w_s1_data)
  );

  // Stage-2 combinational result from the captured operands.
  always_comb begin
    w_f = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      w_f[i] = lu_eval_bit(w_s1_op, w_s1_a[i], w_s1_b[i]);
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  // Flags travel in the same slice as y so they always describe it.
  assign w_s2_in  = {^w_f, ~|w_f, w_f};
  assign out_zero = w_s2_data[W];
  assign out_par  = w_s2_data[W+1];
`else
  assign w_s2_in = w_f;
`endif

  pipe_reg_vr #(.PW(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_in_ready),
    .in_data   (w_s2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_data)
  );

  assign y = w_s2_data[W-1:0];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (W=8): directed scenarios plus a
// randomized stream scored against a word-level reference queue.
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic         out_zero;
  logic         out_par;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;
  logic last_in_xfer;
  logic [W-1:0] exp_q[$];

  logic_unit_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef LOGIC_UNIT_FLAGS_EN
    .out_zero  (out_zero),
    .out_par   (out_par),
`endif
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_f(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      3'd0: return ~x;
      3'd1: return x & z;
      3'd2: return x | z;
      3'd3: return x ^ z;
      3'd4: return ~(x & z);
      3'd5: return ~(x | z);
      3'd6: return ~(x ^ z);
      default: return x;
    endcase
  endfunction

  // Samples both handshakes mid-cycle, scores output beats, then advances one edge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    last_in_xfer = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_cmp++;
      n_out++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: y=%h appeared with no expected beat", y);
      end else begin
        e = exp_q.pop_front();
        if (y !== e) begin
          n_err++;
          $display("FAIL sb_y: got %h expected %h", y, e);
        end
`ifdef LOGIC_UNIT_FLAGS_EN
        n_cmp++;
        if (out_zero !== (e == 8'h00) || out_par !== (^e)) begin
          n_err++;
          $display("FAIL sb_flags: got z=%b p=%b expected z=%b p=%b", out_zero, out_par, (e == 8'h00), ^e);
        end
`endif
      end
    end
    if (last_in_xfer) exp_q.push_back(ref_f(op, a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || y !== 8'h00 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%b y=%h rdy=%b expected 0 00 1", out_valid, y, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'hA5; b = 8'h00; op = OP_NOT;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || y !== 8'h5A) begin
      n_err++;
      $display("FAIL reset_prefill: got v=%b y=%h expected 1 5a", out_valid, y);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || y !== 8'h00) begin
      n_err++;
      $display("FAIL reset_async: got v=%b y=%h expected 0 00", out_valid, y);
    end
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_stale: cycle %0d got v=%b rdy=%b expected 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_single();
    in_valid = 1'b1; a = 8'hA5; b = 8'h3C; op = OP_NOT; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_early: got v=%b expected 0 after one edge", out_valid);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || y !== 8'h5A) begin
      n_err++;
      $display("FAIL single_lat2: got v=%b y=%h expected 1 5a", out_valid, y);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_once: got v=%b expected 0 after one cycle", out_valid);
    end
  endtask

  task automatic test_all_ops();
    logic [W-1:0] exp_tab[8];
    exp_tab = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hCC;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      op = 3'(c);
      tick();
      if (c >= 1 && c <= 8) begin
        n_cmp++;
        if (out_valid !== 1'b1 || y !== exp_tab[c-1]) begin
          n_err++;
          $display("FAIL all_ops[%0d]: got v=%b y=%h expected 1 %h", c-1, out_valid, y, exp_tab[c-1]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] ba[4];
    logic [2:0]   bo[4];
    logic [W-1:0] held;
    int idx;
    int start_out;
    idx = 0;
    start_out = n_out;
    ba = '{8'h11, 8'h22, 8'h44, 8'h88};
    bo = '{3'd0, 3'd3, 3'd5, 3'd7};
    b = 8'h0F;
    out_ready = 1'b0;
    held = 8'h00;
    for (int c = 0; c < 7; c++) begin
      in_valid = (idx < 4);
      a = ba[idx % 4]; op = bo[idx % 4];
      tick();
      if (last_in_xfer) idx++;
      if (c == 1) held = y;
      if (c > 1) begin
        n_cmp++;
        if (out_valid !== 1'b1 || y !== held) begin
          n_err++;
          $display("FAIL bp_hold: cycle %0d got v=%b y=%h expected 1 %h", c, out_valid, y, held);
        end
      end
    end
    n_cmp++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_stall: got captured=%0d rdy=%b expected 2 0", idx, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 50 && (idx < 4 || exp_q.size() != 0); c++) begin
      in_valid = (idx < 4);
      a = ba[idx % 4]; op = bo[idx % 4];
      tick();
      if (last_in_xfer) idx++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_out - start_out !== 4 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL bp_drain: got outputs=%0d pending=%0d expected 4 0", n_out - start_out, exp_q.size());
    end
  endtask

  task automatic test_random();
    int n_in;
    int cyc;
    n_in = 0;
    cyc = 0;
    while (n_in < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      a  = 8'($urandom);
      b  = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      tick();
      cyc++;
      if (last_in_xfer) n_in++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    n_cmp++;
    if (n_in !== 1000 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL rand_done: got beats=%0d pending=%0d expected 1000 0", n_in, exp_q.size());
    end
  endtask

`ifdef LOGIC_UNIT_FLAGS_EN
  task automatic test_flags();
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = OP_XOR;
    tick();
    a = 8'h07; op = OP_PASS;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (y !== 8'h00 || out_zero !== 1'b1 || out_par !== 1'b0) begin
      n_err++;
      $display("FAIL flags_xor: got y=%h z=%b p=%b expected 00 1 0", y, out_zero, out_par);
    end
    tick();
    n_cmp++;
    if (y !== 8'h07 || out_zero !== 1'b0 || out_par !== 1'b1) begin
      n_err++;
      $display("FAIL flags_pass: got y=%h z=%b p=%b expected 07 0 1", y, out_zero, out_par);
    end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    op = 3'd0;
    #12;
    test_reset();
    test_single();
    test_all_ops();
    test_backpressure();
    test_random();
`ifdef LOGIC_UNIT_FLAGS_EN
    test_flags();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
